// File: rtl/alu_result_buf_if.sv
// Handshake/status bundle between the ALU result buffer and its producer/consumer.
// Parity signals exist only when ALU_RESULT_BUF_PARITY_EN is defined.
interface alu_result_buf_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_result;
  logic [OP_W-1:0]   in_opcode;
  logic              in_zero;
  logic              in_carry;
  logic              in_overflow;
  logic              in_negative;
  logic              in_div_by_zero;
  logic              out_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_result;
  logic [OP_W-1:0]   out_opcode;
  logic [4:0]        out_flags;
  logic [OCC_W-1:0]  out_count;
  logic [4:0]        out_sticky;
  logic              in_sticky_clr;
  logic [CNT_W-1:0]  out_err_cnt;
  logic [CNT_W-1:0]  out_drop_cnt;
`ifdef ALU_RESULT_BUF_PARITY_EN
  logic              out_parity;
  logic              in_parity_inject;
`endif

  modport slave (
    input  in_valid, in_result, in_opcode, in_zero, in_carry, in_overflow,
           in_negative, in_div_by_zero, in_ready, in_sticky_clr,
`ifdef ALU_RESULT_BUF_PARITY_EN
    input  in_parity_inject,
    output out_parity,
`endif
    output out_ready, out_valid, out_result, out_opcode, out_flags,
           out_count, out_sticky, out_err_cnt, out_drop_cnt
  );

  modport master (
    output in_valid, in_result, in_opcode, in_zero, in_carry, in_overflow,
           in_negative, in_div_by_zero, in_ready, in_sticky_clr,
`ifdef ALU_RESULT_BUF_PARITY_EN
    output in_parity_inject,
    input  out_parity,
`endif
    input  out_ready, out_valid, out_result, out_opcode, out_flags,
           out_count, out_sticky, out_err_cnt, out_drop_cnt
  );
endinterface

// File: rtl/alu_result_buf.sv
// Registered FIFO stage behind the ALU with sticky flags and saturating error/drop counters.
// Optional per-entry parity storage enabled by defining ALU_RESULT_BUF_PARITY_EN.
module alu_result_buf #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic             in_clk,
  input logic             in_rst,
  alu_result_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [0:0] ST_EMPTY    = 1'b0;
  localparam logic [0:0] ST_NONEMPTY = 1'b1;

  logic [DATA_W-1:0] res_q [DEPTH];
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [4:0]        flg_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic [4:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [4:0]        in_flags_s;
  logic              full_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;

`ifdef ALU_RESULT_BUF_PARITY_EN
  logic par_q [DEPTH];

  function automatic logic even_parity(input logic [OP_W+DATA_W+4:0] v);
    return ^v;
  endfunction
`endif

  assign in_flags_s = {bus.in_div_by_zero, bus.in_negative, bus.in_overflow,
                       bus.in_carry, bus.in_zero};
  assign full_s  = (count_q == OCC_W'(DEPTH));
  // Held low during reset so nothing is taken while state is being cleared.
  assign ready_s = ~in_rst & (~full_s | bus.in_ready);
  assign push_s  = bus.in_valid & ready_s;
  assign pop_s   = (state_q == ST_NONEMPTY) & bus.in_ready;

  assign bus.out_ready    = ready_s;
  assign bus.out_valid    = (state_q == ST_NONEMPTY);
  assign bus.out_result   = res_q[rd_ptr_q];
  assign bus.out_opcode   = op_q[rd_ptr_q];
  assign bus.out_flags    = flg_q[rd_ptr_q];
  assign bus.out_count    = count_q;
  assign bus.out_sticky   = sticky_q;
  assign bus.out_err_cnt  = err_q;
  assign bus.out_drop_cnt = drop_q;
`ifdef ALU_RESULT_BUF_PARITY_EN
  assign bus.out_parity   = par_q[rd_ptr_q];
`endif

  // Next-state for pointers, occupancy and the EMPTY/NONEMPTY view
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == OCC_W'(0)) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = ST_NONEMPTY;
    end
  end

  // Next-state for sticky flags and saturating counters
  always_comb begin
    sticky_d = (bus.in_sticky_clr ? 5'b00000 : sticky_q) |
               (push_s ? in_flags_s : 5'b00000);
    if (push_s && bus.in_div_by_zero && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end else begin
      err_d = err_q;
    end
    if (bus.in_valid && !ready_s && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Control and status registers
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      sticky_q <= 5'b00000;
      err_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; cleared on reset so head outputs read as zero afterwards
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        op_q[i]  <= '0;
        flg_q[i] <= 5'b00000;
`ifdef ALU_RESULT_BUF_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else if (push_s) begin
      res_q[wr_ptr_q] <= bus.in_result;
      op_q[wr_ptr_q]  <= bus.in_opcode;
      flg_q[wr_ptr_q] <= in_flags_s;
`ifdef ALU_RESULT_BUF_PARITY_EN
      par_q[wr_ptr_q] <= even_parity({bus.in_opcode, bus.in_result, in_flags_s})
                         ^ bus.in_parity_inject;
`endif
    end
  end
endmodule

// File: tb/tb_alu_result_buf.sv
// Directed table-driven bench for alu_result_buf plus hand-written corner sequences.
module tb_alu_result_buf;
  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic rdy;

  always #5 in_clk = ~in_clk;

  alu_result_buf_if #(.DATA_W(8), .OP_W(4), .DEPTH(4), .CNT_W(8)) bus ();
  alu_result_buf #(.DATA_W(8), .OP_W(4), .DEPTH(4), .CNT_W(8)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [7:0] res;
    logic [3:0] op;
    logic [4:0] flg;
    logic       r;
    logic       clr;
    logic       e_rdy;
    logic       e_val;
    logic [7:0] e_res;
    logic [3:0] e_op;
    logic [4:0] e_flg;
    logic [2:0] e_cnt;
    logic [4:0] e_sticky;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive after negedge, sample out_ready before the edge, return 1 after it.
  task automatic cyc(input logic v, input logic [7:0] res, input logic [3:0] op,
                     input logic [4:0] flg, input logic r, input logic clr,
                     output logic rdy_pre);
    @(negedge in_clk);
    bus.in_valid       = v;
    bus.in_result      = res;
    bus.in_opcode      = op;
    {bus.in_div_by_zero, bus.in_negative, bus.in_overflow, bus.in_carry, bus.in_zero} = flg;
    bus.in_ready       = r;
    bus.in_sticky_clr  = clr;
    #1 rdy_pre = bus.out_ready;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.in_result = 8'h00;  bus.in_opcode = 4'h0;
    {bus.in_div_by_zero, bus.in_negative, bus.in_overflow, bus.in_carry, bus.in_zero} = 5'b00000;
    bus.in_ready = 1'b0;  bus.in_sticky_clr = 1'b0;
`ifdef ALU_RESULT_BUF_PARITY_EN
    bus.in_parity_inject = 1'b0;
`endif

    //        v    res    op    flg      r     clr   rdy   val   e_res  e_op  e_flg    cnt   sticky   drop
    tbl[0]  = '{1'b1, 8'h3C, 4'h2, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 4'h2, 5'h00, 3'd1, 5'h00, 8'd0};
    tbl[1]  = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 5'h00, 3'd0, 5'h00, 8'd0};
    tbl[2]  = '{1'b1, 8'h11, 4'h1, 5'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 5'h01, 3'd1, 5'h01, 8'd0};
    tbl[3]  = '{1'b1, 8'h22, 4'h3, 5'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 5'h01, 3'd2, 5'h03, 8'd0};
    tbl[4]  = '{1'b1, 8'h33, 4'h4, 5'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 5'h01, 3'd3, 5'h07, 8'd0};
    tbl[5]  = '{1'b1, 8'h44, 4'h5, 5'h08, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 5'h01, 3'd4, 5'h0F, 8'd0};
    tbl[6]  = '{1'b1, 8'h55, 4'h6, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'h1, 5'h01, 3'd4, 5'h0F, 8'd1};
    tbl[7]  = '{1'b1, 8'h66, 4'h7, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 4'h3, 5'h02, 3'd4, 5'h0F, 8'd1};
    tbl[8]  = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 4'h4, 5'h04, 3'd3, 5'h0F, 8'd1};
    tbl[9]  = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 4'h5, 5'h08, 3'd2, 5'h0F, 8'd1};
    tbl[10] = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 4'h7, 5'h00, 3'd1, 5'h0F, 8'd1};
    tbl[11] = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 5'h00, 3'd0, 5'h0F, 8'd1};
    tbl[12] = '{1'b1, 8'h77, 4'h8, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 4'h8, 5'h00, 3'd1, 5'h0F, 8'd1};
    tbl[13] = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 4'h8, 5'h00, 3'd1, 5'h00, 8'd1};
    tbl[14] = '{1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 5'h00, 3'd0, 5'h00, 8'd1};

    // Reset state
    #3;
    chk("rst_ready_low", bus.out_ready, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_count", bus.out_count, 3'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    #1;
    chk("rst_ready_high", bus.out_ready, 1'b1);
    chk("rst_sticky", bus.out_sticky, 5'h00);
    chk("rst_err", bus.out_err_cnt, 8'd0);
    chk("rst_drop", bus.out_drop_cnt, 8'd0);
    chk("rst_result", bus.out_result, 8'h00);

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].v, tbl[i].res, tbl[i].op, tbl[i].flg, tbl[i].r, tbl[i].clr, rdy);
      chk($sformatf("v%0d_ready", i), rdy, tbl[i].e_rdy);
      chk($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].e_val);
      chk($sformatf("v%0d_count", i), bus.out_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_sticky", i), bus.out_sticky, tbl[i].e_sticky);
      chk($sformatf("v%0d_drop", i), bus.out_drop_cnt, tbl[i].e_drop);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_result", i), bus.out_result, tbl[i].e_res);
        chk($sformatf("v%0d_opcode", i), bus.out_opcode, tbl[i].e_op);
        chk($sformatf("v%0d_flags", i), bus.out_flags, tbl[i].e_flg);
`ifdef ALU_RESULT_BUF_PARITY_EN
        chk($sformatf("v%0d_parity", i), bus.out_parity, ^{tbl[i].e_op, tbl[i].e_res, tbl[i].e_flg});
`endif
      end
    end

    // Sticky clear coinciding with a flag-setting push
    cyc(1'b1, 8'h9A, 4'h3, 5'b10100, 1'b0, 1'b0, rdy);
    chk("sticky_set", bus.out_sticky, 5'b10100);
    chk("err_one", bus.out_err_cnt, 8'd1);
    cyc(1'b1, 8'h5B, 4'h4, 5'b00011, 1'b0, 1'b1, rdy);
    chk("sticky_clr_push", bus.out_sticky, 5'b00011);
    chk("sticky_cnt", bus.out_count, 3'd2);
    cyc(1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, rdy);
    chk("sticky_pop_head", bus.out_result, 8'h5B);
    cyc(1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, rdy);
    chk("sticky_drained", bus.out_count, 3'd0);

    // Error counter saturation via streaming div-by-zero pushes
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b1, 8'(k), 4'hD, 5'b10000, 1'b1, 1'b0, rdy);
      if (k == 253) chk("err_fe", bus.out_err_cnt, 8'hFE);
      if (k == 254) chk("err_ff", bus.out_err_cnt, 8'hFF);
    end
    chk("err_sat", bus.out_err_cnt, 8'hFF);
    chk("err_sticky4", bus.out_sticky[4], 1'b1);
    chk("err_stream_cnt", bus.out_count, 3'd1);
    cyc(1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b1, rdy);
    chk("err_sticky_clr", bus.out_sticky, 5'h00);
    chk("err_drained", bus.out_count, 3'd0);

    // Drop counter saturation on a full FIFO
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'hA0 + 8'(k), 4'hA, 5'h00, 1'b0, 1'b0, rdy);
    chk("fill_cnt", bus.out_count, 3'd4);
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b1, 8'hEE, 4'hE, 5'h00, 1'b0, 1'b0, rdy);
      if (k == 253) chk("drop_fe", bus.out_drop_cnt, 8'hFE);
    end
    chk("drop_sat", bus.out_drop_cnt, 8'hFF);
    chk("drop_head", bus.out_result, 8'hA0);
    chk("drop_cnt4", bus.out_count, 3'd4);

    // Asynchronous reset with 3 entries held
    cyc(1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, rdy);
    chk("pre_rst_cnt", bus.out_count, 3'd3);
    chk("pre_rst_head", bus.out_result, 8'hA1);
    bus.in_ready = 1'b0;
    @(negedge in_clk);
    #2 in_rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_count", bus.out_count, 3'd0);
    chk("arst_err", bus.out_err_cnt, 8'd0);
    chk("arst_drop", bus.out_drop_cnt, 8'd0);
    chk("arst_ready", bus.out_ready, 1'b0);
    @(negedge in_clk);
    in_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 4'h0, 5'h00, 1'b1, 1'b0, rdy);
      chk($sformatf("post_rst_valid%0d", k), bus.out_valid, 1'b0);
    end
    cyc(1'b1, 8'hC3, 4'h9, 5'h00, 1'b0, 1'b0, rdy);
    chk("post_rst_head", bus.out_result, 8'hC3);
    chk("post_rst_cnt", bus.out_count, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_buf.md
Name: alu_result_buf

Overview:
- Registered result stage directly downstream of the combinational ALU (alu_comb).
- Captures each ALU result word, its flags and the issuing opcode into a small FIFO.
- Presents captured entries to the consumer over a valid/ready handshake.
- Keeps sticky status flags plus saturating div-by-zero and drop counters for the test/monitor layer.

Parameters:
- DATA_W, 8, width of ALU result (matches ALU operand width)
- OP_W, 4, width of opcode tag stored with each entry
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 8, width of error and drop counters

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  ALU output is a valid result this cycle
- out_ready  output  1  buffer can accept an entry this cycle
- in_result  input  DATA_W  ALU out_result
- in_opcode  input  OP_W  opcode that produced in_result
- in_zero, in_carry, in_overflow, in_negative, in_div_by_zero  input  1 each  ALU flags
- out_valid  output  1  head entry available
- in_ready  input  1  consumer accepts head entry
- out_result  output  DATA_W  head result
- out_opcode  output  OP_W  head opcode
- out_flags  output  5  head flags {div_by_zero, negative, overflow, carry, zero}
- out_count  output  $clog2(DEPTH)+1  current occupancy
- out_sticky  output  5  OR of flags of all accepted entries since last clear
- in_sticky_clr  input  1  clear out_sticky
- out_err_cnt  output  CNT_W  accepted entries with div_by_zero=1, saturating
- out_drop_cnt  output  CNT_W  entries presented while not accepted, saturating

Behaviour:
- Clock and reset: single clock in_clk; reset in_rst is asynchronous, active-high.
- Reset values: wr/rd pointers 0, out_count 0, out_valid 0, out_sticky 0, both counters 0. out_ready is 0 while in_rst is high and 1 after deassertion. Data outputs are don't-care while out_valid=0 and are driven 0 after reset.
- Push: when in_valid && out_ready, the entry {in_result, in_opcode, flags} is written at the rising edge.
- Pop: when out_valid && in_ready, the head is removed at the rising edge.
- Ready: out_ready = !full || in_ready. A simultaneous push and pop when full is legal; occupancy stays DEPTH. This is the only combinational in->out path.
- Latency: an entry pushed at edge N appears on out_valid/out_* after edge N (visible in cycle N+1). Empty FIFO has no bypass.
- Head stability: out_* are stable while out_valid=1 && in_ready=0.
- Pointers: wrap modulo DEPTH. out_count is 0..DEPTH; full is out_count==DEPTH, empty is out_count==0.
- Simultaneous push and pop when empty: push only; out_valid rises next cycle.
- Drop: in_valid && !out_ready increments out_drop_cnt (saturating at all-ones). The entry is discarded and FIFO state is unchanged.
- Sticky: set bitwise from flags of each accepted push. in_sticky_clr clears; if a clear and a setting push coincide, the result is the new push's flags (set wins for that push, old bits cleared).
- Error counter: +1 per accepted push with in_div_by_zero=1. Holds at 2^CNT_W-1. Counters are cleared only by reset.
- Reset mid-operation: contents discarded immediately (asynchronous). No entry is delivered after reset deassertion until a new push.
- FSM: two-state occupancy view (EMPTY, NONEMPTY) derived from out_count; no other control state.

Optional Feature:
- Macro: ALU_RESULT_BUF_PARITY_EN.
- Defined: adds output out_parity (1 bit) = even parity (XOR reduce) over {out_opcode, out_result, out_flags} of the head entry. Parity is computed at push and stored per entry. Adds input in_parity_inject; when high at push, the stored parity bit is inverted (error injection). out_parity resets to 0.
- Undefined: neither port exists, and no parity storage is built.

Test Plan:
- Reset then single push result=8'h3C, opcode=4'h2, flags=5'b00000 -> out_valid=1 the next cycle, out_result=8'h3C, out_count=1; pop -> out_valid=0, out_count=0.
- Push 4 entries with in_ready=0 -> out_count=4, out_ready=0; a 5th in_valid -> out_drop_cnt=1, contents unchanged; pop order matches push order.
- Full FIFO, in_valid=1 and in_ready=1 same cycle -> out_ready=1, out_count stays 4, new entry appears last after 4 pops (pointer wrap checked).
- Push div_by_zero=1 entries 300 times with CNT_W=8 -> out_err_cnt saturates at 8'hFF; out_sticky[4]=1 until in_sticky_clr, then 0.
- in_sticky_clr coincident with push flags=5'b00011 -> out_sticky=5'b00011 the next cycle.
- Assert in_rst mid-stream with 3 entries held -> out_valid=0, out_count=0, counters 0 immediately without a clock edge; no stale entry after release.
